// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the icache, dcache and MainMemory-side signals
//                seen by mem_arbiter.
//                slave  - arbiter view (drives ready/rdata and mem_* command)
//                master - environment view (clients and memory)
//  Ports       : ic_req/ic_addr/ic_rdata/ic_ready              icache side
//                dc_req/dc_we/dc_addr/dc_wdata/dc_rdata/dc_ready dcache side
//                mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready memory
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [LINE_W-1:0] ic_rdata;
    logic              ic_ready;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic [LINE_W-1:0] dc_rdata;
    logic              dc_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_rdata, mem_ready,
        output ic_rdata, ic_ready,
        output dc_rdata, dc_ready,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_rdata, mem_ready,
        input  ic_rdata, ic_ready,
        input  dc_rdata, dc_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-client round-robin arbiter in front of MainMemory.
//                Serialises icache line reads and dcache line reads/writes
//                onto one line port, one single-cycle mem_req per
//                transaction, and routes the completion back to the
//                granted client. All outputs are registered.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - mem_arbiter_if.slave (client and memory signals)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_arbiter_if.slave      bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic c_CL_IC = 1'b0;
    localparam logic c_CL_DC = 1'b1;

    // Line-aligns a byte address (16-byte lines).
    localparam logic [ADDR_W-1:0] c_LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // r_grant is both the current owner and the last_grant used for the
    // round-robin tie break: it only changes when a new grant is made.
    logic              r_grant;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic              r_ic_ready;
    logic              r_dc_ready;
    logic [LINE_W-1:0] r_ic_rdata;
    logic [LINE_W-1:0] r_dc_rdata;

    logic              w_any_req;
    logic              w_pick_dc;
    logic              w_grant_nxt;
    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [LINE_W-1:0] w_mem_wdata_nxt;
    logic              w_ic_ready_nxt;
    logic              w_dc_ready_nxt;
    logic [LINE_W-1:0] w_ic_rdata_nxt;
    logic [LINE_W-1:0] w_dc_rdata_nxt;

    assign w_any_req = bus.ic_req | bus.dc_req;
    // DC wins when it is alone, or on a tie when IC was served last.
    assign w_pick_dc = bus.dc_req & (~bus.ic_req | (r_grant == c_CL_IC));

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= c_CL_IC;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ic_ready  <= 1'b0;
            r_dc_ready  <= 1'b0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ic_ready  <= w_ic_ready_nxt;
            r_dc_ready  <= w_dc_ready_nxt;
            r_ic_rdata  <= w_ic_rdata_nxt;
            r_dc_rdata  <= w_dc_rdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any_req) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (bus.mem_ready) w_state_nxt = c_ST_RESP;
            // RESP always returns to IDLE, so a req still high during the
            // ready cycle is never mistaken for a new request.
            c_ST_RESP:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs. The ready and
    // mem_req registers are loaded one state early so they are high
    // exactly during RESP and ISSUE respectively.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt     = r_grant;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ic_ready_nxt  = 1'b0;
        w_dc_ready_nxt  = 1'b0;
        w_ic_rdata_nxt  = r_ic_rdata;
        w_dc_rdata_nxt  = r_dc_rdata;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt   = w_pick_dc;
                    w_mem_req_nxt = 1'b1;
                    if (w_pick_dc) begin
                        w_mem_we_nxt    = bus.dc_we;
                        w_mem_addr_nxt  = bus.dc_addr & c_LINE_MASK;
                        w_mem_wdata_nxt = bus.dc_wdata;
                    end else begin
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = bus.ic_addr & c_LINE_MASK;
                        w_mem_wdata_nxt = '0;
                    end
                end
            end
            c_ST_WAIT: begin
                if (bus.mem_ready) begin
                    if (r_grant == c_CL_DC) begin
                        w_dc_ready_nxt = 1'b1;
                        if (!r_mem_we) w_dc_rdata_nxt = bus.mem_rdata;
                    end else begin
                        w_ic_ready_nxt = 1'b1;
                        if (!r_mem_we) w_ic_rdata_nxt = bus.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ic_ready  = r_ic_ready;
    assign bus.dc_ready  = r_dc_ready;
    assign bus.ic_rdata  = r_ic_rdata;
    assign bus.dc_rdata  = r_dc_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Bench for mem_arbiter with a MainMemory model, a
//                transaction-level reference model compared every cycle,
//                directed scenarios and a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    localparam logic [127:0] c_DEAD = 128'hDEAD_BEEF_CAFE_BABE_0123_4567_89AB_CDEF;
    localparam logic [127:0] c_ONES = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] c_A5   = {16{8'hA5}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // MainMemory model: mem_ready arrives mem_lat+1 cycles after the
    // mem_req cycle (LATENCY=4 -> mem_req at t+1, mem_ready at t+6).
    // ------------------------------------------------------------------
    logic [127:0] mem_store [logic [31:0]];
    int mem_lat      = 4;
    bit inject_ready = 0;

    function automatic logic [127:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {4{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic mem_init();
        mem_store.delete();
        mem_store[32'h000] = c_DEAD;
        mem_store[32'h010] = c_ONES;
    endtask

    initial begin
        bit           busy = 0;
        int           cnt  = 0;
        bit           s_rst, s_req, q_we;
        logic [31:0]  q_a;
        logic [127:0] q_wd;
        mem_init();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_req = bus.mem_req;
            if (s_req) begin
                q_we = bus.mem_we; q_a = bus.mem_addr; q_wd = bus.mem_wdata;
            end
            @(posedge clk); #1;
            if (s_rst) begin
                busy = 0;
                mem_init();
            end else if (s_req) begin
                busy = 1; cnt = mem_lat;
            end else if (busy) begin
                cnt--;
            end
            if (!s_rst && busy && cnt == 0) begin
                busy = 0;
                bus.mem_ready = 1'b1;
                if (q_we) begin
                    mem_store[q_a] = q_wd;
                    bus.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    bus.mem_rdata = mem_read(q_a);
                end
            end else begin
                bus.mem_ready = inject_ready;
                inject_ready  = 0;
                bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model, transaction view: one transaction at a time; it
    // issues its memory request the cycle after the grant, completes on
    // the first mem_ready after that request, answers the owner one cycle
    // later, and the arbiter is free again after the answer cycle.
    // ------------------------------------------------------------------
    bit           m_valid = 0, m_busy, m_issued, m_wait, m_owner, m_last;
    bit           e_req, e_icr, e_dcr, e_we;
    logic [31:0]  e_addr;
    logic [127:0] e_wdata, e_icd, e_dcd;

    always @(posedge clk) begin
        bit was_req, was_rdy;
        if (rst) begin
            m_valid = 1; m_busy = 0; m_wait = 0; m_last = 0; m_owner = 0;
            e_req = 0; e_icr = 0; e_dcr = 0; e_we = 0;
            e_addr = '0; e_wdata = '0; e_icd = '0; e_dcd = '0;
        end else if (m_valid) begin
            was_req = e_req;
            was_rdy = e_icr | e_dcr;
            e_req = 0; e_icr = 0; e_dcr = 0;
            if (!m_busy) begin
                if (bus.ic_req || bus.dc_req) begin
                    m_owner = (bus.ic_req && bus.dc_req) ? !m_last : bus.dc_req;
                    m_last  = m_owner;
                    m_busy  = 1;
                    e_req   = 1;
                    e_addr  = (m_owner ? bus.dc_addr : bus.ic_addr) & ~32'hF;
                    e_we    = m_owner ? bus.dc_we : 1'b0;
                    e_wdata = m_owner ? bus.dc_wdata : '0;
                end
            end else if (was_req) begin
                m_wait = 1;
            end else if (m_wait && bus.mem_ready) begin
                m_wait = 0;
                if (m_owner) begin
                    e_dcr = 1; if (!e_we) e_dcd = bus.mem_rdata;
                end else begin
                    e_icr = 1; if (!e_we) e_icd = bus.mem_rdata;
                end
            end else if (was_rdy) begin
                m_busy = 0;
            end
        end
    end

    // Per-cycle comparison plus bookkeeping of observed events.
    int n_mreq = 0, n_icr = 0, n_dcr = 0;
    int order[$];
    int mreq_cyc[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                           {e_req, e_we, e_addr, e_wdata});
            chk("ready", {bus.ic_ready, bus.dc_ready}, {e_icr, e_dcr});
            chk("ic_rdata", bus.ic_rdata, e_icd);
            chk("dc_rdata", bus.dc_rdata, e_dcd);
        end
        if (bus.mem_req === 1'b1) begin n_mreq++; mreq_cyc.push_back(cyc); end
        if (bus.ic_ready === 1'b1) begin n_icr++; order.push_back(0); end
        if (bus.dc_ready === 1'b1) begin n_dcr++; order.push_back(1); end
    end

    // ------------------------------------------------------------------
    // Client driver: raise req, hold until ready, drop the cycle after.
    // ------------------------------------------------------------------
    task automatic client_txn(input bit is_dc, input bit we, input logic [31:0] addr,
                              input logic [127:0] wd, output int ts, output int td);
        bit got = 0;
        @(posedge clk); #1;
        if (is_dc) begin
            bus.dc_req = 1; bus.dc_we = we; bus.dc_addr = addr; bus.dc_wdata = wd;
        end else begin
            bus.ic_req = 1; bus.ic_addr = addr;
        end
        ts = cyc;
        td = cyc;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((is_dc ? bus.dc_ready : bus.ic_ready) === 1'b1) begin
                got = 1; td = cyc;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL client_timeout: client %0d got no ready, expected one within 200 cycles", is_dc);
        end
        @(posedge clk); #1;
        if (is_dc) bus.dc_req = 0; else bus.ic_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; bus.ic_req = 0; bus.dc_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ts, td, ts2, td2, k0, k1, k2, mq;
        bit ok;
        bus.ic_req = 0; bus.ic_addr = '0;
        bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_outputs", {bus.mem_req, bus.mem_we, bus.ic_ready, bus.dc_ready,
                              bus.mem_addr, bus.ic_rdata[31:0]}, '0);

        // icache read of line 0 against LATENCY=4 memory
        k0 = n_mreq; k1 = n_dcr; mq = mreq_cyc.size();
        client_txn(0, 0, 32'h000, '0, ts, td);
        chk("ic_latency", td - ts, 7);
        chk("ic_mreq_cycle", mreq_cyc[mq] - ts, 1);
        chk("ic_mreq_count", n_mreq - k0, 1);
        chk("ic_dc_ready_quiet", n_dcr - k1, 0);
        chk("ic_rdata_lit", bus.ic_rdata, c_DEAD);

        // dcache write to 0x01C then read back line 0x010
        client_txn(1, 1, 32'h01C, c_A5, ts, td);
        chk("wr_mem_addr_lit", bus.mem_addr, 32'h010);
        chk("wr_dc_rdata_kept", bus.dc_rdata, '0);
        client_txn(1, 0, 32'h010, '0, ts, td);
        chk("rd_dc_rdata_lit", bus.dc_rdata, c_A5);

        // simultaneous requests right after reset: DC first
        do_reset();
        order.delete(); mreq_cyc.delete();
        fork
            client_txn(0, 0, 32'h000, '0, ts, td);
            client_txn(1, 0, 32'h010, '0, ts2, td2);
        join
        chk("tie_order", {order.size(), order[0], order[1]}, {32'd2, 32'd1, 32'd0});
        chk("tie_mreq_gap", mreq_cyc[1] - mreq_cyc[0], 8);
        chk("tie_dc_rdata_lit", bus.dc_rdata, c_ONES);
        chk("tie_ic_rdata_lit", bus.ic_rdata, c_DEAD);

        // fairness: both clients re-request continuously
        order.delete();
        fork
            for (int i = 0; i < 3; i++) client_txn(0, 0, 32'h000, '0, ts, td);
            for (int i = 0; i < 3; i++) client_txn(1, 0, 32'h010, '0, ts2, td2);
        join
        ok = (order.size() == 6);
        for (int i = 0; i < 6 && ok; i++) ok = (order[i] == ((i % 2 == 0) ? 1 : 0));
        chk("fair_alternation", {order.size(), 31'd0, ok}, {32'd6, 31'd0, 1'b1});

        // reset three cycles after mem_req while waiting on memory
        @(posedge clk); #1;
        bus.ic_req = 1; bus.ic_addr = 32'h000;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.mem_req === 1'b1);
        end
        chk("rst_saw_mreq", ok, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1; bus.ic_req = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_outputs", {bus.mem_req, bus.mem_we, bus.ic_ready, bus.dc_ready,
                                bus.mem_addr, bus.ic_rdata[31:0]}, '0);
        k0 = n_icr + n_dcr;
        repeat (12) @(negedge clk);
        chk("rst_no_ready", n_icr + n_dcr - k0, 0);
        client_txn(0, 0, 32'h004, '0, ts, td);
        chk("rst_after_latency", td - ts, 7);
        chk("rst_after_rdata_lit", bus.ic_rdata, c_DEAD);

        // spurious mem_ready while idle
        client_txn(1, 0, 32'h010, '0, ts, td);
        repeat (2) @(negedge clk);
        k0 = n_icr + n_dcr; k1 = n_mreq;
        inject_ready = 1;
        repeat (6) @(negedge clk);
        chk("spur_no_ready", n_icr + n_dcr - k0, 0);
        chk("spur_no_mreq", n_mreq - k1, 0);
        chk("spur_ic_rdata_lit", bus.ic_rdata, c_DEAD);
        chk("spur_dc_rdata_lit", bus.dc_rdata, c_ONES);

        // randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 40; n++) begin
            mem_lat = $urandom_range(1, 6);
            k2 = $urandom_range(0, 2);
            if (k2 == 0) begin
                client_txn(0, 0, $urandom_range(0, 255), '0, ts, td);
            end else if (k2 == 1) begin
                client_txn(1, $urandom_range(0, 1), $urandom_range(0, 255),
                           {$urandom, $urandom, $urandom, $urandom}, ts, td);
            end else begin
                fork
                    client_txn(0, 0, $urandom_range(0, 255), '0, ts, td);
                    client_txn(1, $urandom_range(0, 1), $urandom_range(0, 255),
                               {$urandom, $urandom, $urandom, $urandom}, ts2, td2);
                join
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        mem_lat = 4;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter sitting directly upstream of MainMemory; shares its single 128-bit line port between the instruction cache (read-only) and the data cache (read/write refill and writeback).
- Serialises requests with round-robin fairness, issues exactly one single-cycle mem_req per transaction, and routes each mem_ready/mem_rdata back to the granted client.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line / memory data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- ic_req  in  1  icache line-read request, level, held until ic_ready
- ic_addr  in  ADDR_W  icache byte address
- ic_rdata  out  LINE_W  line returned to icache
- ic_ready  out  1  one-cycle completion pulse to icache
- dc_req  in  1  dcache request, level, held until dc_ready
- dc_we  in  1  1 = line write, 0 = line read
- dc_addr  in  ADDR_W  dcache byte address
- dc_wdata  in  LINE_W  write line
- dc_rdata  out  LINE_W  line returned to dcache
- dc_ready  out  1  one-cycle completion pulse to dcache
- mem_req  out  1  to MainMemory; one-cycle pulse per transaction
- mem_we  out  1  to MainMemory
- mem_addr  out  ADDR_W  to MainMemory, bits [3:0] forced to 0
- mem_wdata  out  LINE_W  to MainMemory
- mem_rdata  in  LINE_W  from MainMemory, valid in the mem_ready cycle
- mem_ready  in  1  from MainMemory, one-cycle pulse

Behaviour:
- Single clock; rst synchronous, active-high; all state and outputs registered.
- Reset: state=IDLE, last_grant=IC, grant=IC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ic_ready=0, dc_ready=0, ic_rdata=0, dc_rdata=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that client.
  - Both requesting: grant the client other than last_grant. After reset, the first tie therefore goes to DC.
  - On grant: latch addr (low 4 bits cleared), we (forced to 0 for IC), and wdata (IC: 0) into mem_* registers; update last_grant; go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle; go to WAIT. mem_we/mem_addr/mem_wdata stay stable from ISSUE through the end of WAIT.
- WAIT:
  - mem_req=0.
  - On mem_ready: if the transaction is a read, capture mem_rdata into the granted client's rdata register; go to RESP.
  - Writes leave dc_rdata unchanged.
  - There is no timeout.
- RESP: granted client's ready=1 for exactly this cycle; the other client's ready stays 0; go to IDLE.
- Client contract:
  - A client drops req in the cycle after it sees ready. RESP guarantees a stale req is not re-granted.
  - Client inputs are sampled only in IDLE; changes during ISSUE/WAIT/RESP are ignored.
- Latency: grant at IDLE cycle t; mem_req at t+1; client ready one cycle after mem_ready. Against MainMemory (LATENCY=4), mem_ready arrives at t+6 and client ready at t+7.
- mem_ready outside WAIT is ignored; state and outputs are unchanged.
- rdata registers hold their value until the next read completion for that client.
- rst asserted mid-transaction (ISSUE/WAIT/RESP): return to IDLE with reset values next cycle; no ready pulse is produced. MainMemory is reset by the same system reset event.
- At most one transaction outstanding; never two mem_req pulses without an intervening mem_ready.

Test Plan:
- Read, icache only, MainMemory attached: ic_req, ic_addr=0x000 at cycle 0 -> mem_req pulse at cycle 1 only; ic_ready at cycle 7; ic_rdata=128'hDEAD_BEEF_CAFE_BABE_0123_4567_89AB_CDEF; dc_ready stays 0.
- Write then read, dcache only: write dc_addr=0x01C (mem_addr=0x010), dc_wdata=128'hA5A5...A5 -> dc_ready pulse, dc_rdata unchanged. Then read 0x010 -> dc_rdata=128'hA5A5...A5.
- Simultaneous requests after reset: ic_req and dc_req both held, addrs 0x000/0x010:
  - DC is served first, IC second; two mem_req pulses separated by the full transaction.
  - dc_rdata=128'h1111_2222_3333_4444_5555_6666_7777_8888 and ic_rdata=128'hDEAD_BEEF...CDEF.
- Fairness: both clients re-request continuously for 6 transactions -> grants alternate DC, IC, DC, IC, DC, IC; no client is served twice in a row while the other waits.
- Reset mid-WAIT: assert rst for 1 cycle 3 cycles after mem_req -> all outputs zero next cycle; no ready pulse; a fresh ic_req afterwards completes normally.
- Spurious mem_ready in IDLE with no requests -> no ready pulse; rdata registers unchanged; state stays IDLE.
